layer_sequencer: RTL

- Sequences one fully-connected MLP layer over the neuron memory.
- Issues neuron reads, fetches weights and biases, and runs a signed multiply-accumulate.
- Applies scaling, saturation and optional ReLU, then writes each output neuron back to neuron memory.
- Sits between the top-level network controller (start/done) and the neuron memory plus weight memory. Both memories have 1-cycle registered read latency.

---
 rtl/layer_sequencer_if.sv | 39 +++
 rtl/layer_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer_if.sv
// ============================================================================
// layer_sequencer_if
// Controller handshake, layer configuration and neuron/weight memory ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface layer_sequencer_if;
  logic               start;
  logic [11:0]        in_base;
  logic [11:0]        out_base;
  logic [11:0]        n_in;
  logic [11:0]        n_out;
  logic [15:0]        w_base;
  logic               relu_en;
  logic               busy;
  logic               done;
  logic [11:0]        neuron_rd_addr;
  logic signed [15:0] neuron_rd_data;
  logic [15:0]        weight_addr;
  logic signed [15:0] weight_rd_data;
  logic               wr_en;
  logic [11:0]        wr_addr;
  logic signed [15:0] wr_data;

  modport master (
    output start, in_base, out_base, n_in, n_out, w_base, relu_en,
    output neuron_rd_data, weight_rd_data,
    input  busy, done, neuron_rd_addr, weight_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, in_base, out_base, n_in, n_out, w_base, relu_en,
    input  neuron_rd_data, weight_rd_data,
    output busy, done, neuron_rd_addr, weight_addr, wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// layer_sequencer
// Runs one fully-connected layer: read, signed MAC, scale/saturate/ReLU, write.
// Revision: 1.0
// ============================================================================
`default_nettype none

module layer_sequencer #(
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic             clk,
  input  logic             reset,
  layer_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  logic [2:0]              state_q, state_d;
  logic [11:0]             k_q, k_d;
  logic [11:0]             j_q, j_d;
  logic [11:0]             in_base_q, in_base_d;
  logic [11:0]             out_base_q, out_base_d;
  logic [11:0]             n_in_q, n_in_d;
  logic [11:0]             n_out_q, n_out_d;
  logic                    relu_q, relu_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [11:0]             nrd_addr_q, nrd_addr_d;
  logic [15:0]             w_addr_q, w_addr_d;
  logic                    wr_en_q, wr_en_d;
  logic [11:0]             wr_addr_q, wr_addr_d;
  logic signed [15:0]      wr_data_q, wr_data_d;

  logic signed [31:0]      product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_final;
  logic signed [ACC_W-1:0] scaled;
  logic signed [15:0]      result;

  // Post-bias accumulator, scaled back to integer, saturated, optional ReLU
  always_comb begin
    product     = bus.neuron_rd_data * bus.weight_rd_data;
    product_ext = {{(ACC_W-32){product[31]}}, product};
    bias_ext    = {{(ACC_W-16){bus.weight_rd_data[15]}}, bus.weight_rd_data} <<< FRAC_BITS;
    acc_final   = acc_q + bias_ext;
    scaled      = acc_final >>> FRAC_BITS;
    if (scaled > SAT_MAX) begin
      result = 16'sh7FFF;
    end else if (scaled < SAT_MIN) begin
      result = 16'sh8000;
    end else begin
      result = scaled[15:0];
    end
    if (relu_q && result[15]) begin
      result = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    in_base_d  = in_base_q;
    out_base_d = out_base_q;
    n_in_d     = n_in_q;
    n_out_d    = n_out_q;
    relu_d     = relu_q;
    acc_d      = acc_q;
    nrd_addr_d = nrd_addr_q;
    w_addr_d   = w_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          in_base_d  = bus.in_base;
          out_base_d = bus.out_base;
          n_in_d     = bus.n_in;
          n_out_d    = bus.n_out;
          relu_d     = bus.relu_en;
          k_d        = '0;
          j_d        = '0;
          acc_d      = '0;
          nrd_addr_d = bus.in_base;
          w_addr_d   = bus.w_base;
          state_d    = (bus.n_in == 12'd0 || bus.n_out == 12'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Data returning in ISSUE cycle k belongs to input k-1
        if (k_q != 12'd0) begin
          acc_d = acc_q + product_ext;
        end
        // Bias address + 1 is the next neuron's first weight address
        w_addr_d = w_addr_q + 16'd1;
        if (k_q == n_in_q) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 12'd1;
          if (k_q + 12'd1 != n_in_q) begin
            nrd_addr_d = nrd_addr_q + 12'd1;
          end
        end
      end
      S_DRAIN: begin
        acc_d     = acc_final;
        wr_en_d   = 1'b1;
        wr_addr_d = out_base_q + j_q;
        wr_data_d = result;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (j_q == n_out_q - 12'd1) begin
          state_d = S_DONE;
        end else begin
          j_d        = j_q + 12'd1;
          k_d        = '0;
          acc_d      = '0;
          nrd_addr_d = in_base_q;
          state_d    = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      j_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      n_in_q     <= '0;
      n_out_q    <= '0;
      relu_q     <= 1'b0;
      acc_q      <= '0;
      nrd_addr_q <= '0;
      w_addr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      in_base_q  <= in_base_d;
      out_base_q <= out_base_d;
      n_in_q     <= n_in_d;
      n_out_q    <= n_out_d;
      relu_q     <= relu_d;
      acc_q      <= acc_d;
      nrd_addr_q <= nrd_addr_d;
      w_addr_q   <= w_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = (state_q == S_DONE);
  assign bus.neuron_rd_addr = nrd_addr_q;
  assign bus.weight_addr    = w_addr_q;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_addr        = wr_addr_q;
  assign bus.wr_data        = wr_data_q;

endmodule

`default_nettype wire
